// File: rtl/alu_addsub_seq_if.sv
// Request/result bus of the sequential add/sub controller.
// master = requester, slave = alu_addsub_seq.
interface alu_addsub_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_we;
    logic        res_err;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, res_valid, res_data, res_we, res_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, res_valid, res_data, res_we, res_err
    );
endinterface

// File: rtl/alu_addsub_seq.sv
// Sequential ADD/ADC/SUB/SBC/CMP controller driving an external 16-bit add/sub unit.
// Define ALU_SEQ_CARRY_OPS_EN to enable carry-in (second pass) for ADC/SBC.
module alu_addsub_seq (
    input  logic               clk,
    input  logic               rst_n,
    alu_addsub_seq_if.slave    bus,
    output logic [15:0]        alu_x,
    output logic [15:0]        alu_y,
    output logic               alu_sub,
    input  logic [15:0]        alu_z,
    input  logic               alu_cy,
    input  logic               alu_ov,
    output logic               flag_cy,
    output logic               flag_ov,
    output logic               flag_z,
    output logic               flag_s,
    output logic               busy
);
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
`ifdef ALU_SEQ_CARRY_OPS_EN
    logic        cin_reg;
    logic [15:0] z1_reg;
    logic        cy1_reg;
    logic        ov1_reg;
`endif

    logic        sub_op;
    logic        fin_cy;
    logic        fin_ov;

    assign sub_op        = (op_reg == OP_SUB) || (op_reg == OP_SBC) || (op_reg == OP_CMP);
    assign bus.req_ready = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);

    always_comb begin
        alu_x   = '0;
        alu_y   = '0;
        alu_sub = 1'b0;
        case (state_reg)
            EXEC1: begin
                alu_x   = a_reg;
                alu_y   = b_reg;
                alu_sub = sub_op;
            end
`ifdef ALU_SEQ_CARRY_OPS_EN
            EXEC2: begin
                alu_x   = z1_reg;
                alu_y   = 16'h0001;
                alu_sub = sub_op;
            end
`endif
            default: ;
        endcase
    end

    // Final carry/overflow accumulate both passes when the second pass runs.
    always_comb begin
        fin_cy = alu_cy;
        fin_ov = alu_ov;
`ifdef ALU_SEQ_CARRY_OPS_EN
        if (state_reg == EXEC2) begin
            fin_cy = alu_cy | cy1_reg;
            fin_ov = alu_ov | ov1_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
`ifdef ALU_SEQ_CARRY_OPS_EN
            cin_reg       <= 1'b0;
            z1_reg        <= '0;
            cy1_reg       <= 1'b0;
            ov1_reg       <= 1'b0;
`endif
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_we    <= 1'b0;
            bus.res_err   <= 1'b0;
            flag_cy       <= 1'b0;
            flag_ov       <= 1'b0;
            flag_z        <= 1'b0;
            flag_s        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_reg <= bus.req_op;
                        a_reg  <= bus.req_a;
                        b_reg  <= bus.req_b;
`ifdef ALU_SEQ_CARRY_OPS_EN
                        cin_reg <= flag_cy;
`endif
                        if (bus.req_op > OP_CMP) begin
                            // Illegal op: straight to response, flags untouched.
                            state_reg     <= RESP;
                            bus.res_valid <= 1'b1;
                            bus.res_err   <= 1'b1;
                            bus.res_we    <= 1'b0;
                            bus.res_data  <= '0;
                        end else begin
                            state_reg <= EXEC1;
                        end
                    end
                end
                EXEC1: begin
`ifdef ALU_SEQ_CARRY_OPS_EN
                    if (((op_reg == OP_ADC) || (op_reg == OP_SBC)) && cin_reg) begin
                        z1_reg    <= alu_z;
                        cy1_reg   <= alu_cy;
                        ov1_reg   <= alu_ov;
                        state_reg <= EXEC2;
                    end else
`endif
                    begin
                        state_reg     <= RESP;
                        bus.res_valid <= 1'b1;
                        bus.res_we    <= (op_reg != OP_CMP);
                        bus.res_data  <= alu_z;
                        flag_cy       <= fin_cy;
                        flag_ov       <= fin_ov;
                        flag_z        <= (alu_z == 16'h0000);
                        flag_s        <= alu_z[15];
                    end
                end
`ifdef ALU_SEQ_CARRY_OPS_EN
                EXEC2: begin
                    state_reg     <= RESP;
                    bus.res_valid <= 1'b1;
                    bus.res_we    <= (op_reg != OP_CMP);
                    bus.res_data  <= alu_z;
                    flag_cy       <= fin_cy;
                    flag_ov       <= fin_ov;
                    flag_z        <= (alu_z == 16'h0000);
                    flag_s        <= alu_z[15];
                end
`endif
                RESP: begin
                    state_reg     <= IDLE;
                    bus.res_valid <= 1'b0;
                    bus.res_we    <= 1'b0;
                    bus.res_err   <= 1'b0;
                    bus.res_data  <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
